// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode/funct and datapath select encodings for the multi-cycle controller
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2a;
  localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BR = 3'd1, NPC_JAL = 3'd2, NPC_JR = 3'd3;
  localparam logic [1:0] RA_RD = 2'd0, RA_RT = 2'd1, RA_31 = 2'd2;
  localparam logic [2:0] RD_ALU = 3'd0, RD_MDR = 3'd1, RD_IMM = 3'd2, RD_PC4 = 3'd3, RD_SLT = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2, ALU_CMP = 4'd3, ALU_SLL = 4'd4;
  localparam logic [2:0] B_RT = 3'd0, B_SEXT = 3'd1, B_ZEXT = 3'd2, B_SHAMT = 3'd3;
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_TIMEOUT = 2'd1, ERR_ILLEGAL = 2'd2;
  typedef struct packed {
    logic add, sub, sll, slt, jr, ori, lw, sw, beq, lui, jal;
  } iclass_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps an instruction word to a one-hot instruction class plus an illegal flag
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     ic,
  output logic        illegal
);
  logic [5:0] op, fn;
  logic r, unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign r = op == OP_R;
  assign unused_bits = ^instr[25:6];
  assign ic = '{
    add: r && fn == FN_ADD,
    sub: r && fn == FN_SUB,
    sll: r && fn == FN_SLL,
    slt: r && fn == FN_SLT,
    jr:  r && fn == FN_JR,
    ori: op == OP_ORI,
    lw:  op == OP_LW,
    sw:  op == OP_SW,
    beq: op == OP_BEQ,
    lui: op == OP_LUI,
    jal: op == OP_JAL
  };
  assign illegal = ~|ic;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM; define MC_CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_src,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [2:0]  next_pc_op,
  output logic        reg_write,
  output logic [1:0]  reg_addr_op,
  output logic [2:0]  reg_data_op,
  output logic [3:0]  alu_op,
  output logic [2:0]  alu_b_op,
  output logic        a1_op,
  output logic        instr_done,
  output logic        halted,
  output logic [1:0]  err_code
);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [1:0] err;
  iclass_t ic;
  logic illegal, f, e, m, w, h, sel, waiting, tmo, wb_we, ctl;
  mc_decode u_dec (.instr(instr), .ic(ic), .illegal(illegal));
  assign f = !reset && state == S_FETCH;
  assign e = !reset && state == S_EXEC;
  assign m = !reset && state == S_MEM;
  assign w = !reset && state == S_WB;
  assign h = !reset && state == S_HALT;
  assign sel = e | m | w;
  assign ctl = ic.beq | ic.jal | ic.jr;
  assign wb_we = ~(illegal | ic.sw | ic.beq | ic.jr | ic.jal);
  assign waiting = mem_req & ~mem_ack;
  assign tmo = waiting && cnt == CNT_W'(WAIT_MAX - 1);
  assign mem_req = f | m;
  assign mem_src = m;
  assign mem_we = m & ic.sw;
  assign ir_write = f & mem_ack;
  assign pc_write = (e & ctl) | (m & mem_ack & ic.sw) | w;
  assign instr_done = pc_write;
  assign next_pc_op = !e ? NPC_PC4 : ic.beq ? (alu_zero ? NPC_BR : NPC_PC4) :
                      ic.jal ? NPC_JAL : ic.jr ? NPC_JR : NPC_PC4;
  assign reg_write = (e & ic.jal) | (w & wb_we);
  assign reg_addr_op = e & ic.jal ? RA_31 : w & (ic.ori | ic.lw | ic.lui) ? RA_RT : RA_RD;
  assign reg_data_op = e & ic.jal ? RD_PC4 : !w ? RD_ALU : ic.lw ? RD_MDR :
                       ic.lui ? RD_IMM : ic.slt ? RD_SLT : RD_ALU;
  assign alu_op = !sel || ic.add ? ALU_ADD : ic.sub | ic.beq ? ALU_SUB : ic.ori ? ALU_OR :
                  ic.slt ? ALU_CMP : ic.sll ? ALU_SLL : ALU_ADD;
  assign alu_b_op = !sel ? B_RT : ic.ori ? B_ZEXT : ic.lw | ic.sw ? B_SEXT :
                    ic.sll ? B_SHAMT : B_RT;
  assign a1_op = sel & ic.sll;
  assign halted = h;
  assign err_code = reset ? ERR_NONE : err;
  always_comb begin
    next = state;
    case (state)
      S_FETCH:  next = mem_ack ? S_DECODE : tmo ? S_HALT : S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_DECODE: next = illegal ? S_HALT : S_EXEC;
`else
      S_DECODE: next = S_EXEC;
`endif
      S_EXEC:   next = ctl ? S_FETCH : ic.lw | ic.sw ? S_MEM : S_WB;
      S_MEM:    next = mem_ack ? (ic.sw ? S_FETCH : S_WB) : tmo ? S_HALT : S_MEM;
      S_WB:     next = S_FETCH;
      default:  next = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt <= '0;
      err <= ERR_NONE;
    end else begin
      state <= next;
      cnt <= waiting && next == state ? cnt + 1'b1 : '0;
      if (next == S_HALT && state != S_HALT)
        err <= state == S_DECODE ? ERR_ILLEGAL : ERR_TIMEOUT;
    end
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and write-back over several cycles, sharing one unified memory port between instruction fetch and data access.
- Drives the same datapath select encodings as the single-cycle decoder, plus multi-cycle strobes (pc_write, ir_write) and a req/ack memory handshake with a wait-timeout watchdog.

Parameters:
- WAIT_MAX, 15, maximum cycles mem_req may stay high without mem_ack before the timeout fault.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  IR contents; valid from S_DECODE onward.
- alu_zero  input  1  ALU equality flag, used for beq.
- mem_ack  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request.
- mem_src  output  1  0 = address from PC (fetch), 1 = address from ALU result (data).
- mem_we  output  1  write strobe; valid only with mem_req.
- ir_write  output  1  latch memory read data into IR.
- pc_write  output  1  update PC using next_pc_op.
- next_pc_op  output  3  0 = pc+4, 1 = branch target, 2 = jal target, 3 = GPR[rs].
- reg_write  output  1  GRF write enable.
- reg_addr_op  output  2  0 = rd, 1 = rt, 2 = $31.
- reg_data_op  output  3  0 = ALU, 1 = MDR, 2 = imm<<16, 3 = pc+4, 5 = slt.
- alu_op  output  4  0 = add, 1 = sub, 2 = or, 3 = compare, 4 = sll.
- alu_b_op  output  3  0 = rt, 1 = sign-ext imm, 2 = zero-ext imm, 3 = shamt.
- a1_op  output  1  1 for sll.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- halted  output  1  sticky fault indication.
- err_code  output  2  0 = none, 1 = memory timeout, 2 = illegal instruction.

Behaviour:
- Supported instructions: add, sub, sll, slt, jr, ori, lw, sw, beq, lui, jal. nop (sll $0) is handled as sll.
- States: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_HALT=7.
- Outputs are combinational from state, instr and mem_ack. Any strobe not named for a state is 0.
- Reset:
  - While reset is high, every output is 0.
  - The next state is S_FETCH, the wait counter is 0 and err_code is 0.
  - A request in flight is abandoned; the memory must tolerate mem_req dropping.
- S_FETCH:
  - mem_req=1, mem_src=0.
  - On mem_ack: ir_write=1, then go to S_DECODE.
- S_DECODE:
  - No strobes; the datapath latches A/B.
  - Always go to S_EXEC.
- S_EXEC:
  - alu_op and alu_b_op are driven per instruction.
  - beq: pc_write=1, next_pc_op = alu_zero ? 1 : 0; instr_done=1; go to S_FETCH.
  - jal: pc_write=1, next_pc_op=2, reg_write=1, reg_addr_op=2, reg_data_op=3; retire.
  - jr: pc_write=1, next_pc_op=3; retire.
  - lw, sw: go to S_MEM.
  - All other instructions: go to S_WB.
- S_MEM:
  - mem_req=1, mem_src=1, mem_we=sw.
  - On mem_ack, sw: pc_write=1, next_pc_op=0; retire.
  - On mem_ack, lw: MDR latches; go to S_WB.
- S_WB:
  - reg_write=1 with the appropriate addr/data selects.
  - pc_write=1, next_pc_op=0, instr_done=1; go to S_FETCH.
- Latency with zero wait (ack in the same cycle as req):
  - beq, jal, jr: 3 cycles.
  - sw and R/I ALU instructions: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ack=0.
  - Clears on ack or on leaving the state.
  - When the counter reaches WAIT_MAX with no ack: go to S_HALT, err_code=1.
  - An ack in the same cycle the counter reaches WAIT_MAX wins; no fault.
- S_HALT:
  - All strobes 0, halted=1, err_code held.
  - Exits only on reset.
- Register writes to $0 are issued normally; the GRF ignores them.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unrecognised op/funct in S_DECODE goes to S_HALT with err_code=2, and no PC update.
- Undefined: an unrecognised instruction executes as nop, i.e. S_EXEC then S_WB with reg_write=0, pc+4, and instr_done.

Decomposition:
- Package mc_ctrl_pkg:
  - State encodings.
  - Opcode/funct constants.
  - next_pc_op, reg_addr_op, reg_data_op, alu_op, alu_b_op and err_code encodings.
- Sub-module mc_decode (combinational): maps instr to a one-hot instruction class plus illegal flag. The FSM consumes the class.

Test Plan:
- add $3,$1,$2 (0x00221820) with zero-wait ack → states 0,1,2,4; reg_write=1 and reg_addr_op=0 in cycle 4; instr_done pulses once.
- lw (0x8C220004) with 2 wait cycles on each access → 9 cycles total; reg_data_op=1 in S_WB; mem_src=1 in S_MEM.
- beq (0x10220003): alu_zero=1 gives next_pc_op=1 in cycle 3; alu_zero=0 gives next_pc_op=0; no reg_write in either case.
- Hold mem_ack=0 in S_FETCH → S_HALT after 15 wait cycles with err_code=1 and halted=1; later acks are ignored; reset returns to S_FETCH.
- Assert reset during S_MEM of sw → mem_we drops in the same cycle; the next cycle is S_FETCH and no pc_write occurs.
- Opcode 0x3F: with MC_CTRL_ILLEGAL_TRAP_EN, S_HALT with err_code=2; without it, a 4-cycle nop with pc+4 and instr_done.
